// File: rtl/delay_sequencer.sv
// delay_sequencer: drives a downstream delay counter through num_steps
// enable/done handshakes. Each step raises en_req until delay_done returns,
// drops it for one GAP cycle, then raises it again. Reports per-step strobes,
// a completion pulse and a sticky watchdog error if the counter never answers.
module delay_sequencer #(
    parameter int STEP_W  = 8,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              abort,
    input  logic              delay_done,
    output logic              en_req,
    output logic              step_pulse,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    // Watchdog value on the last WAIT cycle before the counter is declared dead.
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic [TO_W-1:0]   wdog;

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            en_req      <= 1'b0;
            step_pulse  <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            remaining   <= '0;
            wdog        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse outputs get a
            // default of 0 here and are only set on the cycle that earns them,
            // so later assignments in the same block simply override.
            step_pulse <= 1'b0;
            done       <= 1'b0;

            if (abort && state != S_IDLE) begin
                // Abort wins over delay_done and timeout; step_idx is kept.
                state  <= S_IDLE;
                en_req <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            timeout_err <= 1'b0;
                            busy        <= 1'b1;
                            if (num_steps != '0) begin
                                remaining <= num_steps;
                                step_idx  <= '0;
                                en_req    <= 1'b1;
                                state     <= S_REQ;
                            end else begin
                                // Empty run: completion pulse with no requests.
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end
                        end
                    end

                    S_REQ: begin
                        en_req <= 1'b1;
                        wdog   <= '0;
                        state  <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (delay_done) begin
                            step_pulse <= 1'b1;
                            step_idx   <= step_idx + 1'b1;
                            remaining  <= remaining - 1'b1;
                            en_req     <= 1'b0;
                            if (remaining == STEP_W'(1)) begin
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end else begin
                                state <= S_GAP;
                            end
                        end else if (wdog == WD_LAST) begin
                            timeout_err <= 1'b1;
                            en_req      <= 1'b0;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end

                    S_GAP: begin
                        // Enable was low for this one cycle; re-request now.
                        en_req <= 1'b1;
                        state  <= S_REQ;
                    end

                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        en_req <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_sequencer.sv
// Directed bench for delay_sequencer built with TIMEOUT=16. Each step advances
// one rising edge and samples 1 time unit later; expectations are hand-derived
// from the edge numbering of each scenario.
module tb_delay_sequencer;

    localparam int STEP_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [STEP_W-1:0] num_steps;
    logic              abort;
    logic              delay_done;
    logic              en_req;
    logic              step_pulse;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              done;
    logic              timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    delay_sequencer #(
        .STEP_W (STEP_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_steps  (num_steps),
        .abort      (abort),
        .delay_done (delay_done),
        .en_req     (en_req),
        .step_pulse (step_pulse),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_steps  = '0;
        abort      = 1'b0;
        delay_done = 1'b0;

        // Reset state
        step();
        step();
        check("rst en_req", en_req, 0);
        check("rst step_pulse", step_pulse, 0);
        check("rst step_idx", step_idx, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        step();

        // Three-step run, responder answers 5 cycles after each en_req rise
        num_steps = 8'd3;
        start     = 1'b1;
        step();                                   // edge 0 -> REQ
        start = 1'b0;
        check("run3 en_req e0", en_req, 1);
        check("run3 busy e0", busy, 1);
        for (int s = 1; s <= 3; s++) begin
            for (int k = 1; k <= 4; k++) begin
                step();
                check("run3 en_req hold", en_req, 1);
                check("run3 no pulse", step_pulse, 0);
            end
            delay_done = 1'b1;
            step();                               // edges 5, 11, 17
            delay_done = 1'b0;
            check("run3 step_pulse", step_pulse, 1);
            check("run3 step_idx", step_idx, 32'(s));
            check("run3 en_req low", en_req, 0);
            if (s < 3) begin
                check("run3 no done mid", done, 0);
                step();                           // en_req back after one GAP cycle
                check("run3 en_req regain", en_req, 1);
                check("run3 pulse cleared", step_pulse, 0);
            end
        end
        check("run3 done e17", done, 1);
        check("run3 busy e17", busy, 1);
        step();                                   // edge 18
        check("run3 done e18", done, 0);
        check("run3 busy e18", busy, 0);
        check("run3 idx final", step_idx, 3);

        // Zero-step run
        num_steps = 8'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("zero done", done, 1);
        check("zero busy", busy, 1);
        check("zero en_req", en_req, 0);
        step();
        check("zero done end", done, 0);
        check("zero busy end", busy, 0);
        check("zero en_req end", en_req, 0);

        // Timeout: num_steps=2, silent responder
        num_steps = 8'd2;
        start     = 1'b1;
        step();                                   // edge 0 -> REQ
        start = 1'b0;
        step();                                   // edge 1 -> WAIT
        for (int k = 2; k <= TIMEOUT; k++) begin  // edges 2..16
            step();
            check("to busy", busy, 1);
            check("to no err yet", timeout_err, 0);
            check("to no done", done, 0);
        end
        step();                                   // edge 17 = 16 cycles into WAIT
        check("to err", timeout_err, 1);
        check("to busy low", busy, 0);
        check("to en_req low", en_req, 0);
        check("to done", done, 0);
        check("to pulse", step_pulse, 0);
        step();
        check("to sticky", timeout_err, 1);

        // Next start clears timeout_err; immediate responder, one step
        num_steps = 8'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("clr err", timeout_err, 0);
        check("clr idx", step_idx, 0);
        step();                                   // WAIT
        delay_done = 1'b1;
        step();
        delay_done = 1'b0;
        check("one pulse", step_pulse, 1);
        check("one done", done, 1);
        check("one idx", step_idx, 1);
        step();
        check("one busy end", busy, 0);

        // Abort during second WAIT of a 4-step run, with a start ignored mid-run
        num_steps = 8'd4;
        start     = 1'b1;
        step();                                   // e0 REQ
        start = 1'b0;
        step();                                   // e1 WAIT
        delay_done = 1'b1;
        step();                                   // e2 -> GAP
        delay_done = 1'b0;
        check("ab first idx", step_idx, 1);
        num_steps = 8'd5;
        start     = 1'b1;
        step();                                   // e3 -> REQ, start ignored
        start = 1'b0;
        check("busy start ignored idx", step_idx, 1);
        check("busy start en_req", en_req, 1);
        step();                                   // e4 -> WAIT
        abort = 1'b1;
        step();                                   // e5 abort
        abort = 1'b0;
        check("ab busy", busy, 0);
        check("ab en_req", en_req, 0);
        check("ab idx", step_idx, 1);
        check("ab done", done, 0);
        step();
        check("ab idle done", done, 0);
        check("ab idle en_req", en_req, 0);

        // delay_done and abort on the same edge
        num_steps = 8'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();                                   // WAIT
        delay_done = 1'b1;
        abort      = 1'b1;
        step();
        delay_done = 1'b0;
        abort      = 1'b0;
        check("col pulse", step_pulse, 0);
        check("col done", done, 0);
        check("col busy", busy, 0);
        check("col idx", step_idx, 0);

        // delay_done exactly on the timeout edge wins
        num_steps = 8'd1;
        start     = 1'b1;
        step();                                   // e0
        start = 1'b0;
        step();                                   // e1 WAIT
        for (int k = 2; k <= TIMEOUT; k++) step(); // edges 2..16
        delay_done = 1'b1;
        step();                                   // edge 17
        delay_done = 1'b0;
        check("tedge pulse", step_pulse, 1);
        check("tedge done", done, 1);
        check("tedge err", timeout_err, 0);
        check("tedge busy", busy, 1);
        step();
        check("tedge err after", timeout_err, 0);
        check("tedge busy after", busy, 0);

        // Reset mid-run during WAIT
        num_steps = 8'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();                                   // WAIT
        delay_done = 1'b1;
        step();                                   // step 1 done, idx 1
        delay_done = 1'b0;
        step();                                   // REQ
        step();                                   // WAIT
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst en_req", en_req, 0);
        check("mrst pulse", step_pulse, 0);
        check("mrst idx", step_idx, 0);
        check("mrst busy", busy, 0);
        check("mrst done", done, 0);
        check("mrst err", timeout_err, 0);
        step();
        check("mrst stays idle", busy, 0);
        check("mrst no en_req", en_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
